bp_me_cce_inst_history: RTL and testbench

- Synthesizable, parametrised instruction history and profiling block for one CCE microcode engine.
- Observes the same fetch stream a trace sink sees: PC, valid, decoded instruction.
- Keeps a circular buffer of the last depth_p executed instructions, one saturating counter per major opcode, and a hang watchdog.
- On freeze (external trigger or hang detection), stops recording and replays the buffer oldest-first over a valid/ready port to a debug host.

---
 rtl/bp_me_cce_inst_history_pkg.sv | 67 ++++++
 rtl/bp_me_cce_inst_history_ring.sv | 66 ++++++
 rtl/bsg_mem_1r1w.sv | 25 ++
 rtl/bp_me_cce_inst_history.sv | 205 ++++++++++++++++++++
 tb/tb_bp_me_cce_inst_history.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_me_cce_inst_history_pkg.sv
// Shared types for the CCE instruction history block: opcodes, instruction
// word, history entry layout and FSM states.
package bp_me_cce_inst_history_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0,
        e_bp_small_cfg   = 1'b1
    } bp_params_e;

    typedef struct packed {
        int unsigned cce_pc_width;
        int unsigned cce_id_width;
    } bp_proc_param_s;

    localparam int unsigned cce_pc_width_gp  = 8;
    localparam int unsigned cce_id_width_gp  = 4;
    localparam int unsigned hist_seq_width_gp = 16;

    // Every configuration shares the packed entry layout below.
    function automatic bp_proc_param_s bp_proc_param(bp_params_e cfg);
        bp_proc_param_s p;
        case (cfg)
            e_bp_small_cfg: p = '{cce_pc_width: cce_pc_width_gp, cce_id_width: cce_id_width_gp};
            default:        p = '{cce_pc_width: cce_pc_width_gp, cce_id_width: cce_id_width_gp};
        endcase
        return p;
    endfunction

    typedef enum logic [2:0] {
        e_op_alu      = 3'b000,
        e_op_branch   = 3'b001,
        e_op_reg_data = 3'b010,
        e_op_mem      = 3'b011,
        e_op_flag     = 3'b100,
        e_op_dir      = 3'b101,
        e_op_queue    = 3'b110,
        e_op_misc     = 3'b111
    } bp_cce_inst_op_e;

    typedef struct packed {
        bp_cce_inst_op_e op;
        logic [3:0]      minor_op;
        logic [24:0]     payload;
    } bp_cce_inst_s;

    typedef enum logic [1:0] {
        e_hist_record = 2'd0,
        e_hist_frozen = 2'd1,
        e_hist_dump   = 2'd2,
        e_hist_done   = 2'd3
    } bp_cce_hist_state_e;

    typedef struct packed {
        logic [cce_id_width_gp-1:0]   cce_id;
        logic [cce_pc_width_gp-1:0]   pc;
        bp_cce_inst_s                 inst;
        logic [hist_seq_width_gp-1:0] seq;
    } bp_cce_hist_entry_s;

    // Stored record; the CCE id is attached on the way out.
    typedef struct packed {
        logic [cce_pc_width_gp-1:0]   pc;
        bp_cce_inst_s                 inst;
        logic [hist_seq_width_gp-1:0] seq;
    } bp_cce_hist_rec_s;

endpackage

// File: rtl/bp_me_cce_inst_history_ring.sv
// Circular history buffer: write pointer and saturating occupancy count
// around a 1r1w memory with an asynchronous read port.
module bp_me_cce_inst_history_ring
    import bp_me_cce_inst_history_pkg::*;
#(
    parameter int unsigned depth_p = 16,
    localparam int unsigned ptr_width_lp = $clog2(depth_p),
    localparam int unsigned cnt_width_lp = ptr_width_lp + 1
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    w_v_i,
    input  bp_cce_hist_rec_s        w_data_i,
    input  logic [ptr_width_lp-1:0] r_addr_i,
    output bp_cce_hist_rec_s        r_data_o,
    output logic [ptr_width_lp-1:0] wr_ptr_o,
    output logic [cnt_width_lp-1:0] count_o
);

    logic [ptr_width_lp-1:0] wr_ptr_d, wr_ptr_q;
    logic [cnt_width_lp-1:0] count_d, count_q;
    logic                    w_en;

    assign w_en = w_v_i && !clear_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (w_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q != cnt_width_lp'(depth_p)) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    bsg_mem_1r1w #(
        .width_p($bits(bp_cce_hist_rec_s)),
        .els_p  (depth_p)
    ) u_mem (
        .w_clk_i (clk_i),
        .w_v_i   (w_en),
        .w_addr_i(wr_ptr_q),
        .w_data_i(w_data_i),
        .r_addr_i(r_addr_i),
        .r_data_o(r_data_o)
    );

    assign wr_ptr_o = wr_ptr_q;
    assign count_o  = count_q;

endmodule

// File: rtl/bsg_mem_1r1w.sv
// One write port, one asynchronous read port register-file memory; contents
// are not reset.
module bsg_mem_1r1w #(
    parameter int unsigned width_p = 8,
    parameter int unsigned els_p   = 16
) (
    input  logic                     w_clk_i,
    input  logic                     w_v_i,
    input  logic [$clog2(els_p)-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [$clog2(els_p)-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem_q [els_p];

    always_ff @(posedge w_clk_i) begin
        if (w_v_i) begin
            mem_q[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_q[r_addr_i];

endmodule

// File: rtl/bp_me_cce_inst_history.sv
// CCE microcode instruction history: records executed instructions, profiles
// opcodes, detects hangs and replays the history oldest-first when frozen.
module bp_me_cce_inst_history
    import bp_me_cce_inst_history_pkg::*;
#(
    parameter bp_params_e  bp_params_p      = e_bp_default_cfg,
    parameter int unsigned depth_p          = 16,
    parameter int unsigned cnt_width_p      = 32,
    parameter int unsigned hang_threshold_p = 1024,
    parameter int unsigned num_ops_p        = 8,
    localparam bp_proc_param_s proc_param_lp = bp_proc_param(bp_params_p),
    localparam int unsigned cce_pc_width_p  = proc_param_lp.cce_pc_width,
    localparam int unsigned cce_id_width_p  = proc_param_lp.cce_id_width
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [cce_id_width_p-1:0]           cce_id_i,
    input  logic [cce_pc_width_p-1:0]           fetch_pc_i,
    input  logic                                instruction_v_i,
    input  logic [$bits(bp_cce_inst_s)-1:0]     instruction_i,
    input  logic                                freeze_i,
    input  logic                                dump_start_i,
    input  logic                                clear_i,
    output logic                                dump_v_o,
    output logic [$bits(bp_cce_hist_entry_s)-1:0] dump_entry_o,
    output logic                                dump_last_o,
    input  logic                                dump_ready_and_i,
    output logic [num_ops_p*cnt_width_p-1:0]    op_count_o,
    output logic                                hang_o,
    output logic [1:0]                          state_o
);

    localparam int unsigned ptr_width_lp   = $clog2(depth_p);
    localparam int unsigned cnt_width_lp   = ptr_width_lp + 1;
    localparam int unsigned stall_width_lp = $clog2(hang_threshold_p + 1);

    bp_cce_hist_state_e       state_q;
    logic [ptr_width_lp-1:0]  rd_ptr_q;
    logic [cnt_width_lp-1:0]  remaining_q;
    logic                     dump_v_q, dump_last_q;

    logic [hist_seq_width_gp-1:0] seq_d, seq_q;
    logic [stall_width_lp-1:0]    stall_d, stall_q;
    logic                         hang_d, hang_q;
    logic [cce_pc_width_p-1:0]    last_pc_d, last_pc_q;
    logic                         last_pc_v_d, last_pc_v_q;
    logic [cnt_width_p-1:0]       op_cnt_d [num_ops_p];
    logic [cnt_width_p-1:0]       op_cnt_q [num_ops_p];

    bp_cce_inst_s             inst;
    bp_cce_hist_rec_s         w_rec, r_rec;
    bp_cce_hist_entry_s       entry;
    logic [ptr_width_lp-1:0]  wr_ptr;
    logic [cnt_width_lp-1:0]  count;
    logic                     in_record, clear_en, rec_v, progress, hang_fire;

    assign inst      = bp_cce_inst_s'(instruction_i);
    assign in_record = (state_q == e_hist_record);
    assign clear_en  = clear_i && (in_record || state_q == e_hist_done);
    assign rec_v     = in_record && instruction_v_i && !clear_i;
    // Re-executing the last recorded PC counts as no progress.
    assign progress  = rec_v && (!last_pc_v_q || fetch_pc_i != last_pc_q);

    always_comb begin
        stall_d     = stall_q;
        last_pc_d   = last_pc_q;
        last_pc_v_d = last_pc_v_q;
        seq_d       = seq_q;
        if (clear_en) begin
            stall_d     = '0;
            last_pc_v_d = 1'b0;
            seq_d       = '0;
        end else if (in_record) begin
            if (progress) begin
                stall_d = '0;
            end else if (stall_q != stall_width_lp'(hang_threshold_p)) begin
                stall_d = stall_q + 1'b1;
            end
            if (rec_v) begin
                last_pc_d   = fetch_pc_i;
                last_pc_v_d = 1'b1;
                seq_d       = seq_q + 1'b1;
            end
        end
    end

    assign hang_fire = in_record && !clear_i && (stall_d == stall_width_lp'(hang_threshold_p));
    assign hang_d    = clear_en ? 1'b0 : (hang_q || hang_fire);

    always_comb begin
        for (int k = 0; k < int'(num_ops_p); k++) begin
            op_cnt_d[k] = op_cnt_q[k];
            if (clear_en) begin
                op_cnt_d[k] = '0;
            end else if (rec_v && int'(inst.op) == k && op_cnt_q[k] != '1) begin
                op_cnt_d[k] = op_cnt_q[k] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_q     <= '0;
            hang_q      <= 1'b0;
            last_pc_q   <= '0;
            last_pc_v_q <= 1'b0;
            seq_q       <= '0;
            for (int k = 0; k < int'(num_ops_p); k++) begin
                op_cnt_q[k] <= '0;
            end
        end else begin
            stall_q     <= stall_d;
            hang_q      <= hang_d;
            last_pc_q   <= last_pc_d;
            last_pc_v_q <= last_pc_v_d;
            seq_q       <= seq_d;
            for (int k = 0; k < int'(num_ops_p); k++) begin
                op_cnt_q[k] <= op_cnt_d[k];
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= e_hist_record;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            dump_v_q    <= 1'b0;
            dump_last_q <= 1'b0;
        end else begin
            unique case (state_q)
                e_hist_record: begin
                    if (!clear_i && (freeze_i || hang_fire)) begin
                        state_q <= e_hist_frozen;
                    end
                end
                e_hist_frozen: begin
                    if (dump_start_i) begin
                        // Oldest entry sits count slots behind the write pointer.
                        rd_ptr_q    <= wr_ptr - ptr_width_lp'(count);
                        remaining_q <= count;
                        if (count == '0) begin
                            state_q <= e_hist_done;
                        end else begin
                            state_q     <= e_hist_dump;
                            dump_v_q    <= 1'b1;
                            dump_last_q <= (count == cnt_width_lp'(1));
                        end
                    end
                end
                e_hist_dump: begin
                    if (dump_ready_and_i) begin
                        rd_ptr_q    <= rd_ptr_q + 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == cnt_width_lp'(1)) begin
                            state_q     <= e_hist_done;
                            dump_v_q    <= 1'b0;
                            dump_last_q <= 1'b0;
                        end else begin
                            dump_last_q <= (remaining_q == cnt_width_lp'(2));
                        end
                    end
                end
                e_hist_done: begin
                    if (clear_i) begin
                        state_q <= e_hist_record;
                    end
                end
                default: state_q <= e_hist_record;
            endcase
        end
    end

    assign w_rec = '{pc: fetch_pc_i, inst: inst, seq: seq_q};

    bp_me_cce_inst_history_ring #(
        .depth_p(depth_p)
    ) u_ring (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (clear_en),
        .w_v_i   (rec_v),
        .w_data_i(w_rec),
        .r_addr_i(rd_ptr_q),
        .r_data_o(r_rec),
        .wr_ptr_o(wr_ptr),
        .count_o (count)
    );

    assign entry = '{cce_id: cce_id_i, pc: r_rec.pc, inst: r_rec.inst, seq: r_rec.seq};

    always_comb begin
        op_count_o = '0;
        for (int k = 0; k < int'(num_ops_p); k++) begin
            op_count_o[k*cnt_width_p +: cnt_width_p] = op_cnt_q[k];
        end
    end

    assign dump_entry_o = entry;
    assign dump_v_o     = dump_v_q;
    assign dump_last_o  = dump_last_q;
    assign hang_o       = hang_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_bp_me_cce_inst_history.sv
// Directed bench for the CCE instruction history: recording, wrap, opcode
// profiling, hang watchdog, stalled replay, reset mid-dump and empty dump.
module tb_bp_me_cce_inst_history;
    import bp_me_cce_inst_history_pkg::*;

    localparam int unsigned CntW = 32;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [3:0]  cce_id_i;
    logic [7:0]  fetch_pc_i;
    logic        instruction_v_i;
    logic [31:0] instruction_i;
    logic        freeze_i, dump_start_i, clear_i, dump_ready_and_i;
    logic        dump_v_o, dump_last_o, hang_o;
    logic [$bits(bp_cce_hist_entry_s)-1:0] dump_entry_o;
    logic [8*CntW-1:0] op_count_o;
    logic [1:0]  state_o;

    bp_cce_hist_entry_s ent;
    assign ent = bp_cce_hist_entry_s'(dump_entry_o);

    int checks = 0;
    int failures = 0;

    bp_me_cce_inst_history #(
        .bp_params_p     (e_bp_default_cfg),
        .depth_p         (16),
        .cnt_width_p     (CntW),
        .hang_threshold_p(8),
        .num_ops_p       (8)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .cce_id_i        (cce_id_i),
        .fetch_pc_i      (fetch_pc_i),
        .instruction_v_i (instruction_v_i),
        .instruction_i   (instruction_i),
        .freeze_i        (freeze_i),
        .dump_start_i    (dump_start_i),
        .clear_i         (clear_i),
        .dump_v_o        (dump_v_o),
        .dump_entry_o    (dump_entry_o),
        .dump_last_o     (dump_last_o),
        .dump_ready_and_i(dump_ready_and_i),
        .op_count_o      (op_count_o),
        .hang_o          (hang_o),
        .state_o         (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CntW-1:0] opc(input int k);
        return op_count_o[k*CntW +: CntW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        instruction_v_i  = 1'b0;
        freeze_i         = 1'b0;
        dump_start_i     = 1'b0;
        clear_i          = 1'b0;
        dump_ready_and_i = 1'b0;
        reset_i          = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
    endtask

    task automatic drive_inst(input logic [7:0] pc, input bp_cce_inst_op_e op);
        bp_cce_inst_s w;
        w = '{op: op, minor_op: 4'h0, payload: 25'(pc)};
        instruction_v_i = 1'b1;
        fetch_pc_i      = pc;
        instruction_i   = w;
    endtask

    task automatic issue(input logic [7:0] pc, input bp_cce_inst_op_e op);
        drive_inst(pc, op);
        tick();
        instruction_v_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        cce_id_i      = 4'h5;
        fetch_pc_i    = '0;
        instruction_i = '0;
        do_reset();
        chk("reset_state", 64'(state_o), 64'(e_hist_record));
        chk("reset_dump_v", 64'(dump_v_o), 64'd0);
        chk("reset_dump_last", 64'(dump_last_o), 64'd0);
        chk("reset_hang", 64'(hang_o), 64'd0);
        chk("reset_op_count", 64'(op_count_o[63:0]), 64'd0);

        // Five instructions, freeze, full-speed replay.
        for (int i = 0; i < 5; i++) issue(8'h10 + 8'(i), e_op_alu);
        freeze_i = 1'b1;
        tick();
        freeze_i = 1'b0;
        chk("t1_frozen", 64'(state_o), 64'(e_hist_frozen));
        dump_start_i     = 1'b1;
        dump_ready_and_i = 1'b1;
        tick();
        dump_start_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t1_beat_v", 64'(dump_v_o), 64'd1);
            chk("t1_beat_pc", 64'(ent.pc), 64'(8'h10 + 8'(i)));
            chk("t1_beat_seq", 64'(ent.seq), 64'(i));
            chk("t1_beat_last", 64'(dump_last_o), 64'(i == 4));
            chk("t1_beat_id", 64'(ent.cce_id), 64'h5);
            tick();
        end
        chk("t1_done", 64'(state_o), 64'(e_hist_done));
        chk("t1_done_v", 64'(dump_v_o), 64'd0);
        chk("t1_alu_before_clear", 64'(opc(int'(e_op_alu))), 64'd5);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("t1_clear_state", 64'(state_o), 64'(e_hist_record));
        chk("t1_clear_alu", 64'(opc(int'(e_op_alu))), 64'd0);

        // Wrap: 20 instructions into a 16-deep ring.
        do_reset();
        for (int i = 0; i < 20; i++) issue(8'(i), e_op_misc);
        freeze_i = 1'b1;
        tick();
        freeze_i         = 1'b0;
        dump_start_i     = 1'b1;
        dump_ready_and_i = 1'b1;
        tick();
        dump_start_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("t2_beat_pc", 64'(ent.pc), 64'(4 + i));
            chk("t2_beat_seq", 64'(ent.seq), 64'(4 + i));
            chk("t2_beat_last", 64'(dump_last_o), 64'(i == 15));
            tick();
        end
        chk("t2_done", 64'(state_o), 64'(e_hist_done));

        // Opcode profile; last instruction coincides with freeze.
        do_reset();
        issue(8'h40, e_op_alu);
        issue(8'h41, e_op_alu);
        issue(8'h42, e_op_branch);
        issue(8'h43, e_op_queue);
        issue(8'h44, e_op_alu);
        freeze_i = 1'b1;
        issue(8'h45, e_op_branch);
        freeze_i = 1'b0;
        chk("t3_frozen", 64'(state_o), 64'(e_hist_frozen));
        chk("t3_alu", 64'(opc(int'(e_op_alu))), 64'd3);
        chk("t3_branch", 64'(opc(int'(e_op_branch))), 64'd2);
        chk("t3_queue", 64'(opc(int'(e_op_queue))), 64'd1);
        for (int k = 2; k < 8; k++) begin
            if (k != int'(e_op_queue)) chk("t3_other", 64'(opc(k)), 64'd0);
        end
        for (int i = 0; i < 3; i++) issue(8'h50 + 8'(i), e_op_alu);
        chk("t3_alu_frozen", 64'(opc(int'(e_op_alu))), 64'd3);

        // Hang watchdog: same PC repeated eight times.
        do_reset();
        issue(8'h20, e_op_alu);
        drive_inst(8'h20, e_op_alu);
        for (int r = 0; r < 8; r++) begin
            tick();
            chk("t4_hang", 64'(hang_o), 64'(r == 7));
            chk("t4_state", 64'(state_o), (r == 7) ? 64'(e_hist_frozen) : 64'(e_hist_record));
        end
        instruction_v_i = 1'b0;
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("t4_clear_ignored", 64'(state_o), 64'(e_hist_frozen));
        chk("t4_hang_sticky", 64'(hang_o), 64'd1);

        // Replay with ready toggling, clear during dump, reset mid-dump.
        do_reset();
        for (int i = 0; i < 6; i++) issue(8'h30 + 8'(i), e_op_dir);
        freeze_i = 1'b1;
        tick();
        freeze_i         = 1'b0;
        dump_start_i     = 1'b1;
        dump_ready_and_i = 1'b0;
        tick();
        dump_start_i = 1'b0;
        idx = 0;
        chk("t5_first_pc", 64'(ent.pc), 64'h30);
        for (int c = 0; c < 6; c++) begin
            dump_ready_and_i = (c % 2 == 1);
            clear_i          = (c == 2);
            tick();
            if (dump_ready_and_i) idx++;
            chk("t5_v", 64'(dump_v_o), 64'd1);
            chk("t5_pc", 64'(ent.pc), 64'(8'h30 + 8'(idx)));
            chk("t5_seq", 64'(ent.seq), 64'(idx));
        end
        dump_ready_and_i = 1'b0;
        clear_i          = 1'b0;
        reset_i          = 1'b1;
        #1;
        chk("t5_reset_state", 64'(state_o), 64'(e_hist_record));
        chk("t5_reset_v", 64'(dump_v_o), 64'd0);
        tick();
        reset_i = 1'b0;

        // Empty history: freeze, dump goes straight to DONE.
        freeze_i = 1'b1;
        tick();
        freeze_i = 1'b0;
        chk("t6_frozen", 64'(state_o), 64'(e_hist_frozen));
        dump_start_i = 1'b1;
        tick();
        dump_start_i = 1'b0;
        chk("t6_done", 64'(state_o), 64'(e_hist_done));
        chk("t6_v0", 64'(dump_v_o), 64'd0);
        tick();
        chk("t6_v1", 64'(dump_v_o), 64'd0);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("t6_clear_state", 64'(state_o), 64'(e_hist_record));
        chk("t6_clear_hang", 64'(hang_o), 64'd0);
        chk("t6_clear_ops", 64'(op_count_o[127:0]), 64'd0);
        // Clear beats both freeze and a valid instruction.
        clear_i  = 1'b1;
        freeze_i = 1'b1;
        issue(8'h60, e_op_alu);
        clear_i  = 1'b0;
        chk("t6_clear_wins_state", 64'(state_o), 64'(e_hist_record));
        chk("t6_clear_wins_alu", 64'(opc(int'(e_op_alu))), 64'd0);
        tick();
        freeze_i     = 1'b0;
        chk("t6_refreeze", 64'(state_o), 64'(e_hist_frozen));
        dump_start_i = 1'b1;
        tick();
        dump_start_i = 1'b0;
        chk("t6_dropped", 64'(state_o), 64'(e_hist_done));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
